led_matrix_scan: RTL and testbench

Row-multiplexed display driver for the 8x8 life grid. It snapshots the 64-bit grid produced by the life engine at each frame boundary, then scans it onto an 8x8 LED matrix one row at a time. Each row is driven for a fixed dwell time, with blanking between rows to prevent ghosting. It is the consumer/display end of the `grid` bus driven by the `main` engine.

---
 rtl/led_matrix_scan_if.sv | 19 +
 rtl/led_matrix_scan.sv | 106 ++++++++++
 tb/tb_led_matrix_scan.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/led_matrix_scan_if.sv
// Grid/display bus between the life engine (master) and the LED matrix scanner (slave).
interface led_matrix_scan_if;
  logic [63:0] grid;
  logic        enable;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_start;
  logic [7:0]  frame_count;

  modport master (
    output grid, enable,
    input  row_sel, col_data, frame_start, frame_count
  );

  modport slave (
    input  grid, enable,
    output row_sel, col_data, frame_start, frame_count
  );
endinterface

// File: rtl/led_matrix_scan.sv
// Row-multiplexed 8x8 LED driver: snapshots the life grid once per frame, then
// scans it row by row with a fixed dwell and optional blanking before each row.
module led_matrix_scan #(
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input logic             clk,
  input logic             reset,
  led_matrix_scan_if.slave bus
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2((MAXC > 2) ? MAXC : 2);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, LOAD, BLANK, DRIVE} state_t;

  state_t        state;
  logic [2:0]    row;
  logic [2:0]    nrow;
  logic [CW-1:0] cnt;
  logic [63:0]   frame_buf;

  function automatic logic [7:0] row_bits(input logic [63:0] fb, input logic [2:0] r);
    return fb[{r, 3'b000} +: 8];
  endfunction

  assign nrow = row + 3'd1;

  // Outputs are registered from the next-state decision so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      row             <= 3'd0;
      cnt             <= '0;
      frame_buf       <= 64'd0;
      bus.row_sel     <= 8'd0;
      bus.col_data    <= 8'd0;
      bus.frame_start <= 1'b0;
      bus.frame_count <= 8'd0;
    end else begin
      bus.frame_start <= 1'b0;
      bus.row_sel     <= 8'd0;
      bus.col_data    <= 8'd0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state           <= LOAD;
            bus.frame_start <= 1'b1;
          end
        end
        LOAD: begin
          frame_buf       <= bus.grid;
          row             <= 3'd0;
          cnt             <= '0;
          bus.frame_count <= bus.frame_count + 8'd1;
          if (BLANK_CYCLES == 0) begin
            state        <= DRIVE;
            bus.row_sel  <= 8'd1;
            bus.col_data <= bus.grid[7:0];
          end else begin
            state <= BLANK;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt          <= '0;
            state        <= DRIVE;
            bus.row_sel  <= 8'd1 << row;
            bus.col_data <= row_bits(frame_buf, row);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == DWELL_LAST) begin
            cnt <= '0;
            if (row != 3'd7) begin
              row <= nrow;
              if (BLANK_CYCLES == 0) begin
                state        <= DRIVE;
                bus.row_sel  <= 8'd1 << nrow;
                bus.col_data <= row_bits(frame_buf, nrow);
              end else begin
                state <= BLANK;
              end
            end else if (bus.enable) begin
              // Back-to-back frames: enable is only looked at after the last row.
              state           <= LOAD;
              bus.frame_start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt          <= cnt + 1'b1;
            bus.row_sel  <= 8'd1 << row;
            bus.col_data <= row_bits(frame_buf, row);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan: stimulus pushes expected output cycles,
// per-instance monitors pop and compare whenever a row strobe or frame_start appears.
module tb_led_matrix_scan;

  typedef struct {
    int         cyc;
    logic [7:0] rs;
    logic [7:0] cd;
    logic       fs;
    logic [7:0] fc;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  bit   mon_on = 1'b0;
  int   errors = 0;
  int   checks = 0;
  ev_t  qa[$];
  ev_t  qb[$];

  led_matrix_scan_if a ();
  led_matrix_scan_if b ();

  led_matrix_scan #(.DWELL_CYCLES(4), .BLANK_CYCLES(1)) dut_a (.clk(clk), .reset(reset), .bus(a));
  led_matrix_scan #(.DWELL_CYCLES(1), .BLANK_CYCLES(0)) dut_b (.clk(clk), .reset(reset), .bus(b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] pack(int c, logic [7:0] rs, logic [7:0] cd, logic fs, logic [7:0] fc);
    return {7'd0, c[31:0], rs, cd, fs, fc};
  endfunction

  // Expected cycles of one frame starting with LOAD at cycle s; events after lastc are dropped.
  task automatic push_frame(input int which, input int s, input logic [63:0] g,
                            input logic [7:0] fc_prev, input int lastc);
    int bl, dw, c;
    ev_t e;
    bl = (which == 0) ? 1 : 0;
    dw = (which == 0) ? 4 : 1;
    e = '{cyc: s, rs: 8'd0, cd: 8'd0, fs: 1'b1, fc: fc_prev};
    if (s <= lastc) begin
      if (which == 0) qa.push_back(e); else qb.push_back(e);
    end
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < dw; k++) begin
        c = s + 1 + r * (bl + dw) + bl + k;
        e = '{cyc: c, rs: 8'd1 << r, cd: g[8*r +: 8], fs: 1'b0, fc: fc_prev + 8'd1};
        if (c <= lastc) begin
          if (which == 0) qa.push_back(e); else qb.push_back(e);
        end
      end
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (($countones(a.row_sel) > 1) || (a.row_sel == 8'd0 && a.col_data != 8'd0))
        check("A invariant", {48'd0, a.row_sel, a.col_data}, {48'd0, a.row_sel, 8'd0});
      if (a.row_sel != 8'd0 || a.frame_start) begin
        ev_t e;
        if (qa.size() == 0) begin
          check("A unexpected output", pack(cyc, a.row_sel, a.col_data, a.frame_start, a.frame_count), 64'd0);
        end else begin
          e = qa.pop_front();
          check("A event", pack(cyc, a.row_sel, a.col_data, a.frame_start, a.frame_count),
                pack(e.cyc, e.rs, e.cd, e.fs, e.fc));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (($countones(b.row_sel) > 1) || (b.row_sel == 8'd0 && b.col_data != 8'd0))
        check("B invariant", {48'd0, b.row_sel, b.col_data}, {48'd0, b.row_sel, 8'd0});
      if (b.row_sel != 8'd0 || b.frame_start) begin
        ev_t e;
        if (qb.size() == 0) begin
          check("B unexpected output", pack(cyc, b.row_sel, b.col_data, b.frame_start, b.frame_count), 64'd0);
        end else begin
          e = qb.pop_front();
          check("B event", pack(cyc, b.row_sel, b.col_data, b.frame_start, b.frame_count),
                pack(e.cyc, e.rs, e.cd, e.fs, e.fc));
        end
      end
    end
  end

  initial begin
    int s1, s4, s5, sb;
    logic [63:0] diag, ones, pat_a, pat_b;
    diag  = 64'h8040201008040201;
    ones  = 64'hFFFF_FFFF_FFFF_FFFF;
    pat_a = 64'h0123456789ABCDEF;
    pat_b = 64'hF0E1D2C3B4A59687;
    a.grid = 64'd0; a.enable = 1'b0;
    b.grid = 64'd0; b.enable = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    mon_on = 1'b1;
    check("A reset outputs", {40'd0, a.row_sel, a.col_data, 7'd0, a.frame_start}, 64'd0);
    check("A reset frame_count", {56'd0, a.frame_count}, 64'd0);
    check("B reset outputs", {40'd0, b.row_sel, b.col_data, 7'd0, b.frame_start}, 64'd0);
    reset = 1'b0;

    // Idle with enable low: any strobe or frame_start is flagged by the monitor.
    wait_until(cyc + 100);
    check("A idle frame_count", {56'd0, a.frame_count}, 64'd0);
    check("B idle frame_count", {56'd0, b.frame_count}, 64'd0);

    // Diagonal frames, grid swapped mid-frame, enable dropped during row 2 of the third frame.
    a.grid = diag;
    s1 = cyc + 1;
    push_frame(0, s1,      diag, 8'd0, 1 << 30);
    push_frame(0, s1 + 41, diag, 8'd1, 1 << 30);
    push_frame(0, s1 + 82, ones, 8'd2, 1 << 30);
    a.enable = 1'b1;
    wait_until(s1 + 41 + 18);
    a.grid = ones;
    wait_until(s1 + 82 + 13);
    a.enable = 1'b0;
    wait_until(s1 + 82 + 41 + 60);
    check("A queue drained after enable drop", qa.size(), 64'd0);
    check("A frame_count holds", {56'd0, a.frame_count}, 64'd3);

    // Reset during row 5 of a frame, then restart with enable still high.
    a.enable = 1'b1;
    s4 = cyc + 1;
    push_frame(0, s4, ones, 8'd3, s4 + 28);
    wait_until(s4 + 28);
    reset = 1'b1;
    wait_until(s4 + 29);
    check("A reset mid-frame row_sel", {56'd0, a.row_sel}, 64'd0);
    check("A reset mid-frame col_data", {56'd0, a.col_data}, 64'd0);
    check("A reset mid-frame frame_start", {63'd0, a.frame_start}, 64'd0);
    check("A reset mid-frame frame_count", {56'd0, a.frame_count}, 64'd0);
    check("A queue drained before reset", qa.size(), 64'd0);
    a.grid = pat_a;
    reset = 1'b0;

    // 257 back-to-back frames: frame_count wraps 255 -> 0 -> 1.
    s5 = s4 + 30;
    for (int k = 0; k < 257; k++)
      push_frame(0, s5 + 41 * k, pat_a, k[7:0], 1 << 30);
    wait_until(s5 + 41 * 256 + 5);
    a.enable = 1'b0;
    wait_until(s5 + 41 * 257 + 20);
    check("A queue drained after wrap", qa.size(), 64'd0);
    check("A frame_count after 257 frames", {56'd0, a.frame_count}, 64'd1);

    // No blanking, single-cycle dwell: 9-cycle frames with rows strobed back to back.
    b.grid = pat_b;
    sb = cyc + 1;
    for (int k = 0; k < 257; k++)
      push_frame(1, sb + 9 * k, pat_b, k[7:0], 1 << 30);
    b.enable = 1'b1;
    wait_until(sb + 9 * 256 + 3);
    b.enable = 1'b0;
    wait_until(sb + 9 * 257 + 10);
    check("B queue drained after wrap", qb.size(), 64'd0);
    check("B frame_count after 257 frames", {56'd0, b.frame_count}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
